product_accumulator: RTL and testbench
======================================

// Module: product_accumulator
// PURPOSE
//   Downstream stage of the 3x3 unsigned multiplier. Accepts its 6-bit products over a
//   valid/ready stream and sums a frame of COUNT products. Presents the frame sum on a
//   registered valid/ready output.
//   Used for dot-product / MAC style reductions of multiplier results.
// PARAMETERS
//   PW     6   product (input) width in bits; matches the multiplier p output
//   ACC_W  8   accumulator and result width in bits
//   COUNT  8   products per frame; legal range 2..256
// PORTS
//   clk        in   1      rising-edge clock
//   rst        in   1      synchronous reset, active-high
//   clr        in   1      synchronous frame abort, active-high
//   in_valid   in   1      in_p holds a valid product
//   in_ready   out  1      block accepts in_p this cycle
//   in_p       in   PW     unsigned product from the multiplier
//   out_valid  out  1      out_sum holds a completed frame sum
//   out_ready  in   1      consumer accepts out_sum this cycle
//   out_sum    out  ACC_W  unsigned frame sum
//   out_ovf    out  1      frame sum exceeded 2^ACC_W-1; qualified by out_valid
// BEHAVIOUR
//   - One clock domain. Reset is synchronous, active-high. Reset priority: rst > clr > handshakes.
//   - Reset values: state=ACC, acc=0, cnt=0, in_ready=1, out_valid=0, out_sum=0, out_ovf=0.
//   - Internal state: acc[ACC_W-1:0], sticky ovf bit, cnt[$clog2(COUNT)-1:0].
//   - FSM has two states: ACC and DONE.
//   - ACC state:
//     - in_ready=1; out_valid=0.
//     - Accept occurs when in_valid && in_ready: sum = acc + zero-extended in_p, computed at ACC_W+1 bits.
//     - On an accept with cnt != COUNT-1: acc <= sum (see CONFIGURATION); cnt <= cnt+1.
//     - On an accept with cnt == COUNT-1: out_sum <= final sum; out_ovf <= final ovf;
//       acc <= 0; cnt <= 0; go to DONE.
//   - DONE state:
//     - in_ready=0; out_valid=1.
//     - out_sum and out_ovf are held stable until the handshake.
//     - On out_valid && out_ready: go to ACC; out_valid drops the next cycle.
//     - No bypass: a new frame cannot start in the cycle the result is taken.
//   - Timing:
//     - Latency: out_valid rises the cycle after the last product is accepted.
//     - Throughput: COUNT+1 cycles per frame minimum, i.e. one bubble cycle.
//   - in_valid without an accept (in DONE) does not alter acc or cnt.
//     The producer must hold in_p until it is accepted.
//   - clr from any state: acc=0, ovf=0, cnt=0, out_valid=0, go to ACC.
//     Any pending result is discarded. An in_valid in the same cycle is ignored.
//   - rst mid-frame or mid-result: identical effect to clr, plus all outputs take their reset values.
//   - Ovf is sticky within a frame: set when any partial sum carries out of ACC_W bits.
//     Cleared at frame start.
// CONFIGURATION
//   Macro ACC_SATURATE_EN:
//   - Defined: on carry-out, acc clamps to 2^ACC_W-1 and stays clamped for the rest of the frame.
//     out_sum = 2^ACC_W-1 and out_ovf=1.
//   - Undefined: acc wraps modulo 2^ACC_W. out_ovf still reports the sticky carry.
//   - Handshake timing is identical in both builds.
// TESTING
//   1. rst held 2 cycles -> in_ready=1, out_valid=0, out_sum=0, out_ovf=0.
//   2. 8 back-to-back products 1,2,3,4,5,6,7,8, out_ready=1:
//      -> out_valid 1 cycle after the 8th accept; out_sum=36, out_ovf=0;
//         in_ready=0 for that one cycle.
//   3. 8 products of 49 (7x7):
//      -> without macro: out_sum=136, out_ovf=1;
//      -> with ACC_SATURATE_EN: out_sum=255, out_ovf=1.
//   4. Frame of all 10s, out_ready=0 for 5 cycles:
//      -> out_valid and out_sum=80 held; in_ready=0;
//      -> in_valid pulses are ignored; next frame sums from 0.
//   5. clr after 3 products of 63, then 8 products of 2:
//      -> out_sum=16, out_ovf=0; no earlier result appears.
//   6. rst asserted in DONE with out_ready=0 -> out_valid=0, out_sum=0 next cycle;
//      the next frame behaves as in test 2.

Source files
------------

// File: rtl/product_accumulator.sv
// -----------------------------------------------------------------------------
// product_accumulator
//   Sums frames of COUNT unsigned products that arrive from the 3x3 multiplier
//   over a valid/ready stream. Each frame sum is presented on a registered
//   valid/ready output, together with a flag that reports overflow of the
//   accumulator.
//
//   Optional feature: define ACC_SATURATE_EN to clamp the accumulator at
//   2^ACC_W-1 on overflow. When the macro is undefined (the default build),
//   the accumulator wraps modulo 2^ACC_W. out_ovf reports the sticky carry
//   in both builds.
//
// Parameters
//   PW     product width (bits)
//   ACC_W  accumulator / result width (bits)
//   COUNT  products per frame (2..256)
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous reset, active-high
//   clr        synchronous frame abort, active-high (discards any result)
//   in_valid   in_p holds a valid product
//   in_ready   block accepts in_p this cycle (registered)
//   in_p       unsigned product
//   out_valid  out_sum/out_ovf hold a completed frame result (registered)
//   out_ready  consumer accepts the result this cycle
//   out_sum    unsigned frame sum
//   out_ovf    frame sum exceeded 2^ACC_W-1, qualified by out_valid
// -----------------------------------------------------------------------------
module product_accumulator #(
  parameter int PW    = 6,
  parameter int ACC_W = 8,
  parameter int COUNT = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [PW-1:0]    in_p,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_sum,
  output logic             out_ovf
);

  localparam int CW = (COUNT > 1) ? $clog2(COUNT) : 1;
  localparam logic [CW-1:0] LAST = CW'(COUNT - 1);

  typedef enum logic {ACC, DONE} state_t;

  state_t           state_reg;
  logic [ACC_W-1:0] acc_reg;
  logic             ovf_reg;
  logic [CW-1:0]    cnt_reg;

  logic [ACC_W:0]   sum;
  logic [ACC_W-1:0] acc_next;
  logic             ovf_next;
  logic             accept;

  // One extra bit on the adder captures the carry out of the accumulator.
  always_comb begin
    sum      = {1'b0, acc_reg} + {{(ACC_W + 1 - PW){1'b0}}, in_p};
    ovf_next = ovf_reg | sum[ACC_W];
`ifdef ACC_SATURATE_EN
    // Once any carry has happened in this frame the accumulator stays pinned
    // at full scale, so the sticky flag doubles as the clamp condition.
    acc_next = ovf_next ? {ACC_W{1'b1}} : sum[ACC_W-1:0];
`else
    acc_next = sum[ACC_W-1:0];
`endif
    accept   = in_valid && in_ready;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ACC;
      acc_reg   <= '0;
      ovf_reg   <= 1'b0;
      cnt_reg   <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_ovf   <= 1'b0;
    end else if (clr) begin
      // Abort: partial frame and any pending result are dropped; out_sum and
      // out_ovf keep their old contents but are no longer qualified.
      state_reg <= ACC;
      acc_reg   <= '0;
      ovf_reg   <= 1'b0;
      cnt_reg   <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      case (state_reg)
        ACC: begin
          if (accept) begin
            if (cnt_reg == LAST) begin
              out_sum   <= acc_next;
              out_ovf   <= ovf_next;
              acc_reg   <= '0;
              ovf_reg   <= 1'b0;
              cnt_reg   <= '0;
              state_reg <= DONE;
              in_ready  <= 1'b0;
              out_valid <= 1'b1;
            end else begin
              acc_reg <= acc_next;
              ovf_reg <= ovf_next;
              cnt_reg <= cnt_reg + CW'(1);
            end
          end
        end
        DONE: begin
          // No bypass: in_ready only rises the cycle after the result is taken.
          if (out_ready) begin
            state_reg <= ACC;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
          end
        end
        default: begin
          state_reg <= ACC;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_product_accumulator.sv
// -----------------------------------------------------------------------------
// tb_product_accumulator
//   Directed bench for product_accumulator. Expected frame results come from a
//   small arithmetic model, are pushed to a scoreboard queue when a frame is
//   driven, and are popped and compared when the DUT presents out_valid.
// -----------------------------------------------------------------------------
module tb_product_accumulator;

  localparam int PW    = 6;
  localparam int ACC_W = 8;
  localparam int COUNT = 8;

  logic             clk;
  logic             rst;
  logic             clr;
  logic             in_valid;
  logic             in_ready;
  logic [PW-1:0]    in_p;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_sum;
  logic             out_ovf;

  typedef struct {
    int unsigned sum;
    int unsigned ovf;
  } exp_t;

  exp_t sb[$];
  int   total_checks;
  int   passed_checks;

  product_accumulator #(.PW(PW), .ACC_W(ACC_W), .COUNT(COUNT)) dut (
    .clk      (clk),
    .rst      (rst),
    .clr      (clr),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_p     (in_p),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_sum  (out_sum),
    .out_ovf  (out_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int unsigned obs, input int unsigned exp);
    total_checks++;
    assert (obs === exp) passed_checks++;
    else $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    $display("check %-18s got %0d expected %0d", tag, obs, exp);
  endtask

  // Reference arithmetic for a frame whose i-th product is base + i*inc.
  task automatic model(input int base, input int inc, output exp_t e);
    int unsigned a;
    int unsigned t;
    int unsigned o;
    a = 0;
    o = 0;
    for (int i = 0; i < COUNT; i++) begin
      t = a + base + i * inc;
      if (t > 255) o = 1;
`ifdef ACC_SATURATE_EN
      a = (o != 0) ? 255 : t;
`else
      a = t % 256;
`endif
    end
    e.sum = a;
    e.ovf = o;
  endtask

  // Drive n products (base + i*inc), waiting for in_ready before each.
  task automatic drive(input int n, input int base, input int inc);
    int waited;
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1;
      in_p     = PW'(base + i * inc);
      waited   = 0;
      while (!in_ready && waited < 100) begin
        step();
        waited++;
      end
      if (waited >= 100) chk("in_ready_timeout", 32'(in_ready), 1);
      step();
    end
    in_valid = 1'b0;
    in_p     = '0;
  endtask

  task automatic send_frame(input int base, input int inc);
    exp_t e;
    model(base, inc, e);
    drive(COUNT, base, inc);
    sb.push_back(e);
    $display("frame sent base=%0d inc=%0d expect sum=%0d ovf=%0d", base, inc, e.sum, e.ovf);
  endtask

  task automatic take_result(input string tag);
    int   waited;
    exp_t e;
    waited = 0;
    while (!out_valid && waited < 100) begin
      step();
      waited++;
    end
    chk({tag, "_valid"}, 32'(out_valid), 1);
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 0, 1);
    end else begin
      e = sb.pop_front();
      chk({tag, "_sum"}, 32'(out_sum), e.sum);
      chk({tag, "_ovf"}, 32'(out_ovf), e.ovf);
    end
    out_ready = 1'b1;
    step();
  endtask

  initial begin
    total_checks  = 0;
    passed_checks = 0;
    rst       = 1'b1;
    clr       = 1'b0;
    in_valid  = 1'b0;
    in_p      = '0;
    out_ready = 1'b0;

    // 1. reset state
    step();
    step();
    chk("rst_in_ready", 32'(in_ready), 1);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_sum", 32'(out_sum), 0);
    chk("rst_out_ovf", 32'(out_ovf), 0);
    rst = 1'b0;

    // 2. ramp 1..8, result one cycle after last accept, one bubble
    out_ready = 1'b1;
    send_frame(1, 1);
    chk("lat_out_valid", 32'(out_valid), 1);
    chk("lat_in_ready", 32'(in_ready), 0);
    take_result("ramp");
    chk("bubble_out_valid", 32'(out_valid), 0);
    chk("bubble_in_ready", 32'(in_ready), 1);

    // 3. overflowing frame of 49s
    send_frame(49, 0);
    take_result("ovf49");

    // 4. result held under backpressure, stray in_valid ignored
    out_ready = 1'b0;
    send_frame(10, 0);
    for (int k = 0; k < 5; k++) begin
      in_valid = 1'b1;
      in_p     = PW'(33);
      step();
      chk("hold_out_valid", 32'(out_valid), 1);
      chk("hold_out_sum", 32'(out_sum), 80);
      chk("hold_in_ready", 32'(in_ready), 0);
    end
    in_valid = 1'b0;
    in_p     = '0;
    take_result("hold10");
    send_frame(1, 1);
    take_result("after_hold");

    // 5. clr mid-frame discards partial sum and ignores same-cycle in_valid
    drive(3, 63, 0);
    clr      = 1'b1;
    in_valid = 1'b1;
    in_p     = PW'(63);
    step();
    clr      = 1'b0;
    in_valid = 1'b0;
    in_p     = '0;
    chk("clr_out_valid", 32'(out_valid), 0);
    chk("clr_in_ready", 32'(in_ready), 1);
    send_frame(2, 0);
    take_result("after_clr");

    // 6. rst while a result is pending
    out_ready = 1'b0;
    send_frame(1, 1);
    void'(sb.pop_back());
    chk("pre_rst_out_valid", 32'(out_valid), 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rst6_out_valid", 32'(out_valid), 0);
    chk("rst6_out_sum", 32'(out_sum), 0);
    chk("rst6_out_ovf", 32'(out_ovf), 0);
    chk("rst6_in_ready", 32'(in_ready), 1);
    out_ready = 1'b1;
    send_frame(1, 1);
    chk("rst6_lat_valid", 32'(out_valid), 1);
    take_result("after_rst");

    chk("sb_drained", 32'(sb.size()), 0);

    $display("%0d/%0d checks passed", passed_checks, total_checks);
    $finish;
  end

endmodule
